c8_dncnt: RTL and testbench



---
 rtl/c8_dncnt_if.sv | 36 +++
 rtl/c8_dncnt.sv | 79 +++++++
 tb/tb_c8_dncnt.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/c8_dncnt_if.sv
// c8_dncnt control/data bundle.
// master drives load/count controls; slave returns count state.
interface c8_dncnt_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             load_en;
  logic             src_sel;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             cnt_en;
  logic             auto_rld;
  logic             inv_sel;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] rld_q;
  logic             zero;
  logic             borrow;
  logic             done;
  logic [WIDTH-1:0] rd_q;

  modport master (
    output clr, load_en, src_sel,
    output data_a, data_b,
    output cnt_en, auto_rld, inv_sel,
    input  cnt_q, rld_q, zero,
    input  borrow, done, rd_q
  );

  modport slave (
    input  clr, load_en, src_sel,
    input  data_a, data_b,
    input  cnt_en, auto_rld, inv_sel,
    output cnt_q, rld_q, zero,
    output borrow, done, rd_q
  );
endinterface

// File: rtl/c8_dncnt.sv
// Registered loadable down-counter with
// borrow/expiry reporting and optional auto-reload.
module c8_dncnt #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  c8_dncnt_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] ld_val;

  assign ld_val = bus.src_sel ? bus.data_a
                              : bus.data_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rld_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rld_q    <= rld_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rld_d    = rld_q;
    borrow_d = 1'b0;
    if (bus.clr) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (bus.load_en) begin
      cnt_d   = ld_val;
      rld_d   = ld_val;
      state_d = COUNT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        EXPIRED: state_d = EXPIRED;
        COUNT: begin
          if (bus.cnt_en) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else begin
              // expiry replaces the 0 -> all-ones wrap
              borrow_d = 1'b1;
              if (bus.auto_rld) cnt_d = rld_q;
              else state_d = EXPIRED;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.cnt_q  = cnt_q;
  assign bus.rld_q  = rld_q;
  assign bus.zero   = (cnt_q == '0);
  assign bus.borrow = borrow_q;
  assign bus.done   = (state_q == EXPIRED);
  assign bus.rd_q   = bus.inv_sel ? ~cnt_q
                                  : ~rld_q;
endmodule

// File: tb/tb_c8_dncnt.sv
// Self-checking bench for c8_dncnt: directed
// vector table, corner sequences, random vs model.
module tb_c8_dncnt;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  c8_dncnt_if #(.WIDTH(8)) bus ();

  c8_dncnt #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       c, l, s;
    bit [7:0] a, b;
    bit       e, ar, inv;
    bit [7:0] ecnt, erld;
    bit       ebor, edone;
    bit [7:0] erd;
  } vec_t;

  vec_t vt[$];

  // behavioural reference state
  int m_cnt, m_rld;
  bit m_run, m_exp, m_bor;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic drive(bit c, bit l, bit s,
                       bit [7:0] a, bit [7:0] b,
                       bit e, bit ar, bit inv);
    bus.clr = c;  bus.load_en = l;
    bus.src_sel = s;
    bus.data_a = a; bus.data_b = b;
    bus.cnt_en = e; bus.auto_rld = ar;
    bus.inv_sel = inv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rld = 0;
    m_run = 0; m_exp = 0; m_bor = 0;
  endtask

  // one clock of the rules, from current inputs
  task automatic model_step();
    int v;
    v = bus.src_sel ? int'(bus.data_a)
                    : int'(bus.data_b);
    m_bor = 0;
    if (bus.clr) begin
      m_cnt = 0; m_run = 0; m_exp = 0;
    end else if (bus.load_en) begin
      m_cnt = v; m_rld = v;
      m_run = 1; m_exp = 0;
    end else if (m_run && bus.cnt_en) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else begin
        m_bor = 1;
        if (bus.auto_rld) m_cnt = m_rld;
        else begin
          m_run = 0; m_exp = 1;
        end
      end
    end
  endtask

  task automatic model_check(string nm);
    int rd;
    rd = bus.inv_sel ? (~m_cnt & 255)
                     : (~m_rld & 255);
    chk({nm, ".cnt"}, 32'(bus.cnt_q), m_cnt);
    chk({nm, ".rld"}, 32'(bus.rld_q), m_rld);
    chk({nm, ".zero"}, 32'(bus.zero),
        (m_cnt == 0) ? 1 : 0);
    chk({nm, ".bor"}, 32'(bus.borrow), m_bor);
    chk({nm, ".done"}, 32'(bus.done), m_exp);
    chk({nm, ".rd"}, 32'(bus.rd_q), rd);
  endtask

  task automatic add(bit c, bit l, bit s,
                     bit [7:0] a, bit [7:0] b,
                     bit e, bit ar, bit inv,
                     bit [7:0] ecnt, bit [7:0] erld,
                     bit ebor, bit edone,
                     bit [7:0] erd);
    vec_t v;
    v.c = c; v.l = l; v.s = s;
    v.a = a; v.b = b; v.e = e;
    v.ar = ar; v.inv = inv;
    v.ecnt = ecnt; v.erld = erld;
    v.ebor = ebor; v.edone = edone;
    v.erd = erd;
    vt.push_back(v);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #12;
    chk("rst.cnt", 32'(bus.cnt_q), 0);
    chk("rst.rld", 32'(bus.rld_q), 0);
    chk("rst.zero", 32'(bus.zero), 1);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.bor", 32'(bus.borrow), 0);
    chk("rst.rd", 32'(bus.rd_q), 32'hFF);
    rst = 1'b0;
    tick();

    // c l s a b e ar inv | cnt rld bor done rd
    add(0,1,1,8'h03,0,0,0,1, 3,3,0,0,8'hFC);
    add(0,0,1,8'h03,0,1,0,1, 2,3,0,0,8'hFD);
    add(0,0,1,8'h03,0,1,0,1, 1,3,0,0,8'hFE);
    add(0,0,1,8'h03,0,1,0,1, 0,3,0,0,8'hFF);
    add(0,0,1,8'h03,0,1,0,1, 0,3,1,1,8'hFF);
    add(0,0,1,8'h03,0,1,0,1, 0,3,0,1,8'hFF);
    add(0,0,1,8'h03,0,1,0,0, 0,3,0,1,8'hFC);
    add(0,1,0,0,8'h02,0,1,0, 2,2,0,0,8'hFD);
    for (int i = 0; i < 3; i++) begin
      add(0,0,0,0,0,1,1,1, 1,2,0,0,8'hFE);
      add(0,0,0,0,0,1,1,1, 0,2,0,0,8'hFF);
      add(0,0,0,0,0,1,1,1, 2,2,1,0,8'hFD);
    end
    add(0,1,1,8'h00,0,0,1,1, 0,0,0,0,8'hFF);
    add(0,0,1,0,0,1,1,1, 0,0,1,0,8'hFF);
    add(0,0,1,0,0,1,1,1, 0,0,1,0,8'hFF);
    add(0,0,1,0,0,1,1,1, 0,0,1,0,8'hFF);
    add(1,1,1,8'h7F,0,1,1,1, 0,0,0,0,8'hFF);
    add(0,0,1,8'h7F,0,1,1,1, 0,0,0,0,8'hFF);
    add(0,1,1,8'h00,0,0,0,1, 0,0,0,0,8'hFF);
    add(0,1,1,8'h7F,0,1,0,1, 8'h7F,8'h7F,0,0,8'h80);
    add(0,0,1,8'h7F,0,1,0,1, 8'h7E,8'h7F,0,0,8'h81);
    add(0,1,1,8'hA5,0,0,0,1, 8'hA5,8'hA5,0,0,8'h5A);
    add(0,0,1,0,0,1,0,1, 8'hA4,8'hA5,0,0,8'h5B);
    add(0,0,1,0,0,0,0,0, 8'hA4,8'hA5,0,0,8'h5A);

    foreach (vt[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(vt[i].c, vt[i].l, vt[i].s,
            vt[i].a, vt[i].b, vt[i].e,
            vt[i].ar, vt[i].inv);
      tick();
      chk({nm, ".cnt"}, 32'(bus.cnt_q), 32'(vt[i].ecnt));
      chk({nm, ".rld"}, 32'(bus.rld_q), 32'(vt[i].erld));
      chk({nm, ".zero"}, 32'(bus.zero),
          (vt[i].ecnt == 0) ? 1 : 0);
      chk({nm, ".bor"}, 32'(bus.borrow), 32'(vt[i].ebor));
      chk({nm, ".done"}, 32'(bus.done), 32'(vt[i].edone));
      chk({nm, ".rd"}, 32'(bus.rd_q), 32'(vt[i].erd));
    end

    // async reset mid-count, away from any edge
    drive(0, 1, 1, 8'h07, 0, 0, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0, 1, 0, 1);
    tick(); tick();
    chk("pre.cnt", 32'(bus.cnt_q), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.cnt", 32'(bus.cnt_q), 0);
    chk("arst.rld", 32'(bus.rld_q), 0);
    chk("arst.zero", 32'(bus.zero), 1);
    chk("arst.done", 32'(bus.done), 0);
    chk("arst.bor", 32'(bus.borrow), 0);
    chk("arst.rd", 32'(bus.rd_q), 32'hFF);
    #1;
    rst = 1'b0;
    tick(); tick();
    chk("idle.cnt", 32'(bus.cnt_q), 0);
    chk("idle.bor", 32'(bus.borrow), 0);

    // load racing an expiry edge: load wins
    drive(0, 1, 0, 0, 8'h01, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    drive(0, 1, 0, 0, 8'h04, 1, 0, 1);
    tick();
    chk("ldexp.cnt", 32'(bus.cnt_q), 4);
    chk("ldexp.bor", 32'(bus.borrow), 0);
    chk("ldexp.done", 32'(bus.done), 0);

    // randomized run against the model
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bit [7:0] a, b;
      a = ($urandom_range(0, 3) == 0) ?
          8'($urandom) : 8'($urandom_range(0, 4));
      b = ($urandom_range(0, 3) == 0) ?
          8'($urandom) : 8'($urandom_range(0, 4));
      drive($urandom_range(0, 40) == 0,
            $urandom_range(0, 9) == 0,
            1'($urandom), a, b,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0,
            1'($urandom));
      model_step();
      tick();
      model_check($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
